// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings and constants for the memory arbiter
package mem_arbiter_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_DATA = 2'd1,
      ARB_INST = 2'd2
   } arb_state_e;
   localparam logic [3:0] ARB_SEL_ALL = 4'b1111;
endpackage

// File: rtl/mem_arbiter_timer.sv
// mem_arbiter_timer: bus-cycle counter that flags when TIMEOUT cycles have elapsed without an ack
module mem_arbiter_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] cnt;
   // count waited bus cycles, holding at TIMEOUT until cleared by the next grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !done) cnt <= cnt + 1'b1;
   end
   assign done = (cnt == W'(TIMEOUT));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory bus between instruction fetch and data access
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_sel,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              bus_cyc,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [3:0]        bus_sel,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              stall_o,
   output logic              err_o
);
   arb_state_e state, nxt;
   logic last_inst, wait_i, wait_d, idle, pick_d, pick_i, go, fin, abort, done;
   // a request whose ack is pulsing this cycle is already served and must not be granted again
   assign wait_i  = i_req & ~i_ack;
   assign wait_d  = d_req & ~d_ack;
   assign stall_o = wait_i | wait_d;
   mem_arbiter_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (go),
      .en  (~idle & ~bus_ack),
      .done(done)
   );
   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ARB_IDLE;
      else state <= nxt;
   end
   // next state: grant from idle, return to idle on ack or timeout
   always_comb begin
      nxt = idle ? (pick_d ? ARB_DATA : pick_i ? ARB_INST : ARB_IDLE)
                 : ((fin | abort) ? ARB_IDLE : state);
   end
   // control decode: data wins a tie only when fetch was granted last; ack beats timeout
   always_comb begin
      idle   = (state == ARB_IDLE);
      pick_d = idle & wait_d & (~wait_i | last_inst);
      pick_i = idle & wait_i & ~pick_d;
      go     = pick_d | pick_i;
      fin    = ~idle & bus_ack;
      abort  = ~idle & ~bus_ack & done;
   end
   // bus request latching and response capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_inst <= 1'b1;
         bus_cyc   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_sel   <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         err_o <= 1'b0;
         if (go) begin
            last_inst <= pick_i;
            bus_cyc   <= 1'b1;
            bus_we    <= pick_d & d_we;
            bus_addr  <= pick_d ? d_addr : i_addr;
            bus_wdata <= pick_d ? d_wdata : '0;
            bus_sel   <= pick_d ? d_sel : ARB_SEL_ALL;
         end
         if (fin | abort) begin
            bus_cyc <= 1'b0;
            err_o   <= abort;
            i_ack   <= (state == ARB_INST);
            d_ack   <= (state == ARB_DATA);
            if (state == ARB_INST) i_rdata <= fin ? bus_rdata : '0;
            if (state == ARB_DATA && (abort || !bus_we)) d_rdata <= fin ? bus_rdata : '0;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus checked every cycle against a transaction-level model
module tb_mem_arbiter;
   localparam int TO = 15;
   logic clk = 0, rst = 0;
   logic i_req = 0, d_req = 0, d_we = 0, bus_ack = 0;
   logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, bus_rdata = 0;
   logic [3:0] d_sel = 0;
   logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
   logic [3:0] bus_sel;
   logic i_ack, d_ack, bus_cyc, bus_we, stall_o, err_o;
   int n_chk = 0, n_fail = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
      .d_rdata(d_rdata), .d_ack(d_ack), .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .stall_o(stall_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // transaction-level model: owner 0 none, 1 data, 2 fetch; age = bus cycles spent waiting
   int m_owner, m_age, pick;
   bit m_last_d, wd, wi;
   logic m_cyc, m_we, m_iack, m_dack, m_err;
   logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
   logic [3:0] m_sel;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_owner = 0; m_age = 0; m_last_d = 0;
         m_cyc = 0; m_we = 0; m_iack = 0; m_dack = 0; m_err = 0;
         m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0; m_sel = 0;
      end else begin
         wd = d_req && !m_dack;
         wi = i_req && !m_iack;
         m_iack = 0; m_dack = 0; m_err = 0;
         if (m_owner == 0) begin
            pick = (wd && wi) ? (m_last_d ? 2 : 1) : (wd ? 1 : (wi ? 2 : 0));
            if (pick == 1) begin
               m_owner = 1; m_cyc = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
               m_sel = d_sel; m_last_d = 1; m_age = 0;
            end else if (pick == 2) begin
               m_owner = 2; m_cyc = 1; m_we = 0; m_addr = i_addr; m_wdata = 0;
               m_sel = 4'hF; m_last_d = 0; m_age = 0;
            end
         end else begin
            m_age++;
            if (bus_ack || m_age == TO + 1) begin
               if (m_owner == 1) begin
                  m_dack = 1;
                  if (!bus_ack) m_drdata = 0;
                  else if (!m_we) m_drdata = bus_rdata;
               end else begin
                  m_iack = 1;
                  m_irdata = bus_ack ? bus_rdata : 32'h0;
               end
               m_err = !bus_ack; m_cyc = 0; m_owner = 0;
            end
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      chk("bus_cyc", bus_cyc, m_cyc);
      chk("i_ack", i_ack, m_iack);
      chk("d_ack", d_ack, m_dack);
      chk("err_o", err_o, m_err);
      chk("i_rdata", i_rdata, m_irdata);
      chk("d_rdata", d_rdata, m_drdata);
      chk("stall_o", stall_o, (i_req && !m_iack) || (d_req && !m_dack));
      if (m_cyc) begin
         chk("bus_we", bus_we, m_we);
         chk("bus_addr", bus_addr, m_addr);
         chk("bus_wdata", bus_wdata, m_wdata);
         chk("bus_sel", bus_sel, m_sel);
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cyc;
      for (int k = 0; k < 40; k++) begin
         if (bus_cyc) return;
         tick;
      end
      chk("wait_bus_cyc_timeout", 0, 1);
   endtask

   task automatic serve(input logic [31:0] data);
      wait_cyc;
      bus_ack = 1; bus_rdata = data;
      tick;
      bus_ack = 0; bus_rdata = 0;
      if (i_ack) i_req = 0;
      if (d_ack) d_req = 0;
   endtask

   initial begin
      int k;
      bus_ack = 1;
      tick; tick;
      chk("rst_bus_cyc", bus_cyc, 0);
      chk("rst_outs", {i_ack, d_ack, err_o, stall_o, bus_we, bus_sel}, 0);
      chk("rst_data", {i_rdata, d_rdata}, 0);
      chk("rst_bus", {bus_addr, bus_wdata}, 0);
      rst = 1; bus_ack = 0;
      tick; tick; tick;
      chk("idle_no_req", bus_cyc, 0);

      i_req = 1; i_addr = 32'h10;
      tick;
      chk("fetch_cyc", bus_cyc, 1);
      chk("fetch_addr", bus_addr, 32'h10);
      chk("fetch_sel", bus_sel, 4'b1111);
      chk("fetch_we", bus_we, 0);
      bus_ack = 1; bus_rdata = 32'h3401_0020;
      tick;
      bus_ack = 0; bus_rdata = 0;
      chk("fetch_ack", i_ack, 1);
      chk("fetch_rdata", i_rdata, 32'h3401_0020);
      chk("fetch_cyc_drop", bus_cyc, 0);
      i_req = 0;
      tick;
      chk("fetch_ack_one", i_ack, 0);
      chk("fetch_stall", stall_o, 0);

      rst = 0; tick; rst = 1;
      d_req = 1; d_we = 1; d_addr = 32'h8000_0004; d_wdata = 32'hDEAD_BEEF; d_sel = 4'b0011;
      i_req = 1; i_addr = 32'h20;
      tick;
      chk("tie1_we", bus_we, 1);
      chk("tie1_addr", bus_addr, 32'h8000_0004);
      chk("tie1_wdata", bus_wdata, 32'hDEAD_BEEF);
      chk("tie1_sel", bus_sel, 4'b0011);
      chk("tie1_stall", stall_o, 1);
      serve(32'h5555_5555);
      chk("tie1_dack", d_ack, 1);
      chk("tie1_wr_rdata", d_rdata, 0);
      tick;
      chk("tie1_second_fetch", bus_addr, 32'h20);
      chk("tie1_second_we", bus_we, 0);
      serve(32'hA5A5_0001);
      chk("tie1_iack", i_ack, 1);
      tick;

      d_req = 1; d_we = 0; d_addr = 32'h200; d_sel = 4'hF;
      serve(32'h1234_5678);
      chk("lone_read", d_rdata, 32'h1234_5678);
      tick;
      d_req = 1; d_addr = 32'h300; i_req = 1; i_addr = 32'h30;
      tick;
      chk("tie2_fetch_first", bus_addr, 32'h30);
      serve(32'h0BAD_F00D);
      tick;
      chk("tie2_then_data", bus_addr, 32'h300);
      serve(32'h7777_0000);
      tick;

      d_req = 1; d_we = 0; d_addr = 32'h40;
      wait_cyc;
      k = 0;
      while (!d_ack && k < 40) begin
         tick; k++;
      end
      chk("to_latency", k, TO + 1);
      chk("to_err", err_o, 1);
      chk("to_rdata", d_rdata, 0);
      chk("to_cyc", bus_cyc, 0);
      d_req = 0;
      tick;
      chk("to_err_one", err_o, 0);

      d_req = 1; d_addr = 32'h44;
      wait_cyc;
      repeat (TO) tick;
      chk("edge_still_busy", bus_cyc, 1);
      bus_ack = 1; bus_rdata = 32'hCAFE_0044;
      tick;
      bus_ack = 0; bus_rdata = 0;
      chk("edge_ack", d_ack, 1);
      chk("edge_no_err", err_o, 0);
      chk("edge_rdata", d_rdata, 32'hCAFE_0044);
      d_req = 0;
      tick;

      i_req = 1; i_addr = 32'h80;
      tick;
      chk("mid_cyc_up", bus_cyc, 1);
      #2;
      rst = 0; i_req = 0;
      #1;
      chk("mid_async_drop", bus_cyc, 0);
      tick;
      rst = 1;
      bus_ack = 1;
      tick;
      bus_ack = 0;
      for (int j = 0; j < 4; j++) begin
         chk("mid_no_ack", i_ack, 0);
         tick;
      end
      chk("mid_idle", bus_cyc, 0);
      tick; tick;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
